// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage types, reset address and redirect-target helper.
package mips_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_e;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    function automatic logic [31:0] pick_target(
        input logic jr_taken, input logic j_taken,
        input logic [31:0] jr_target, input logic [31:0] j_target, input logic [31:0] br_target
    );
        logic [31:0] t;
        t = jr_taken ? jr_target : j_taken ? j_target : br_target;
        return {t[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// pc_fetch_ctrl_if: instruction-memory, decode and redirect signals of the fetch stage.
interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_npc;
    logic        jr_taken;
    logic [31:0] jr_target;
    logic        j_taken;
    logic [31:0] j_target;
    logic        br_taken;
    logic [31:0] br_target;
    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_npc,
        input  imem_ack, imem_rdata, if_ready, jr_taken, jr_target, j_taken, j_target, br_taken, br_target
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_npc,
        output imem_ack, imem_rdata, if_ready, jr_taken, jr_target, j_taken, j_target, br_taken, br_target
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch sequencer issuing one imem request at a time and holding the
// fetched word for decode; redirects during an outstanding request drain it first.
module pc_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    pc_fetch_ctrl_if.master bus
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, instr_q, instr_d, ifpc_q, ifpc_d, npc_q, npc_d, pend_q, pend_d;
    logic         req_q, req_d, valid_q, valid_d;
    logic         redirect;
    logic [31:0]  target;

    always_comb begin
        redirect = bus.jr_taken | bus.j_taken | bus.br_taken;
        target   = pick_target(bus.jr_taken, bus.j_taken, bus.jr_target, bus.j_target, bus.br_target);
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        pend_d   = pend_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack && redirect) begin
                    pc_d = target;
                end else if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    ifpc_d  = pc_q;
                    state_d = HOLD;
                end else if (redirect) begin
                    // address must stay put until the memory acks, so park the target
                    pend_d  = target;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redirect || bus.if_ready) begin
                    pc_d    = redirect ? target : pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (bus.imem_ack) begin
                    pc_d    = pend_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        npc_d   = ifpc_d + 32'd4;
        req_d   = state_d != HOLD;
        valid_d = state_d == HOLD;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ifpc_q  <= RESET_PC;
            npc_q   <= RESET_PC + 32'd4;
            pend_q  <= '0;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            npc_q   <= npc_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_instr  = instr_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.if_npc    = npc_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed stimulus with a scoreboard of expected fetch addresses
// and presented instructions, checked by an independent monitor.
module tb_pc_fetch_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] addr_q[$];
    logic [31:0] fetch_q[$];

    pc_fetch_ctrl_if bus ();
    pc_fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign bus.imem_rdata = mem(bus.imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        bus.jr_taken = 0; bus.j_taken = 0; bus.br_taken = 0;
        bus.jr_target = 0; bus.j_target = 0; bus.br_target = 0;
    endtask

    // monitor: every ack and every accepted instruction must match the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.imem_req && bus.imem_ack) begin
                if (addr_q.size() == 0) chk("unexpected_ack_addr", bus.imem_addr, 32'hxxxx_xxxx);
                else chk("imem_addr", bus.imem_addr, addr_q.pop_front());
            end
            if (bus.if_valid && bus.if_ready && !(bus.jr_taken || bus.j_taken || bus.br_taken)) begin
                if (fetch_q.size() == 0) chk("unexpected_fetch_pc", bus.if_pc, 32'hxxxx_xxxx);
                else begin
                    logic [31:0] p;
                    p = fetch_q.pop_front();
                    chk("if_pc", bus.if_pc, p);
                    chk("if_instr", bus.if_instr, mem(p));
                    chk("if_npc", bus.if_npc, p + 32'd4);
                end
            end
        end
    end

    task automatic chk_reset_state();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
        chk("rst_addr", bus.imem_addr, 32'h0000_3000);
        chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_instr", bus.if_instr, 32'd0);
        chk("rst_pc", bus.if_pc, 32'h0000_3000);
        chk("rst_npc", bus.if_npc, 32'h0000_3004);
    endtask

    initial begin
        reset = 1; bus.imem_ack = 1; bus.if_ready = 0;
        clear_redirects();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state();
        // back-to-back: ack and ready tied high
        step();
        reset = 0; bus.imem_ack = 1; bus.if_ready = 1;
        addr_q.push_back(32'h3000); addr_q.push_back(32'h3004); addr_q.push_back(32'h3008);
        fetch_q.push_back(32'h3000); fetch_q.push_back(32'h3004); fetch_q.push_back(32'h3008);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("pulse_valid", {31'd0, bus.if_valid}, (i % 2 == 1) ? 32'd1 : 32'd0);
            step();
        end
        // ack delayed three cycles at 0x300C
        bus.imem_ack = 0; bus.if_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_addr", bus.imem_addr, 32'h300C);
            chk("wait_req", {31'd0, bus.imem_req}, 32'd1);
            step();
        end
        bus.imem_ack = 1; addr_q.push_back(32'h300C);
        step();
        bus.imem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
            chk("hold_instr", bus.if_instr, mem(32'h300C));
            chk("hold_pc", bus.if_pc, 32'h300C);
            step();
        end
        bus.if_ready = 1; fetch_q.push_back(32'h300C);
        step();
        bus.if_ready = 0;
        // j redirect from HOLD overrides if_ready
        bus.imem_ack = 1; addr_q.push_back(32'h3010);
        step();
        bus.imem_ack = 0; bus.if_ready = 1; bus.j_taken = 1; bus.j_target = 32'h0000_3100;
        step();
        clear_redirects(); bus.if_ready = 0;
        bus.imem_ack = 1; addr_q.push_back(32'h3100);
        step();
        bus.imem_ack = 0; bus.if_ready = 1; fetch_q.push_back(32'h3100);
        step();
        bus.if_ready = 0;
        // branch while ack pending -> drain; jr during drain ignored
        bus.br_taken = 1; bus.br_target = 32'h3040;
        step();
        clear_redirects(); bus.jr_taken = 1; bus.jr_target = 32'h7000;
        @(negedge clk);
        chk("drain_addr", bus.imem_addr, 32'h3104);
        chk("drain_req", {31'd0, bus.imem_req}, 32'd1);
        step();
        clear_redirects(); bus.imem_ack = 1; addr_q.push_back(32'h3104);
        step();
        bus.imem_ack = 0;
        @(negedge clk);
        chk("post_drain_valid", {31'd0, bus.if_valid}, 32'd0);
        chk("post_drain_addr", bus.imem_addr, 32'h3040);
        bus.imem_ack = 1; addr_q.push_back(32'h3040);
        step();
        bus.imem_ack = 0; bus.if_ready = 1; fetch_q.push_back(32'h3040);
        step();
        bus.if_ready = 0;
        // jr beats j on an ack cycle; low bits of target cleared
        bus.imem_ack = 1; addr_q.push_back(32'h3044);
        bus.jr_taken = 1; bus.jr_target = 32'h5003; bus.j_taken = 1; bus.j_target = 32'h6000;
        step();
        clear_redirects(); bus.imem_ack = 0;
        @(negedge clk);
        chk("prio_addr", bus.imem_addr, 32'h5000);
        chk("prio_valid", {31'd0, bus.if_valid}, 32'd0);
        bus.imem_ack = 1; addr_q.push_back(32'h5000);
        step();
        bus.imem_ack = 0; bus.if_ready = 1; fetch_q.push_back(32'h5000);
        step();
        bus.if_ready = 0;
        // reach 0xFFFF_FFFC via a misaligned jr and wrap
        bus.jr_taken = 1; bus.jr_target = 32'hFFFF_FFFE;
        step();
        clear_redirects(); bus.imem_ack = 1; addr_q.push_back(32'h5004);
        step();
        addr_q.push_back(32'hFFFF_FFFC);
        step();
        bus.imem_ack = 0;
        @(negedge clk);
        chk("wrap_npc", bus.if_npc, 32'h0000_0000);
        bus.if_ready = 1; fetch_q.push_back(32'hFFFF_FFFC);
        step();
        bus.if_ready = 0;
        @(negedge clk);
        chk("wrap_addr", bus.imem_addr, 32'h0000_0000);
        bus.imem_ack = 1; addr_q.push_back(32'h0000_0000);
        step();
        bus.imem_ack = 0; bus.if_ready = 1; fetch_q.push_back(32'h0000_0000);
        step();
        bus.if_ready = 0;
        // reset during an outstanding request, ack during reset ignored
        step();
        @(negedge clk);
        reset = 1; bus.imem_ack = 1;
        #1;
        chk_reset_state();
        step();
        chk_reset_state();
        reset = 0; bus.imem_ack = 0;
        step();
        bus.imem_ack = 1; addr_q.push_back(32'h3000);
        step();
        bus.imem_ack = 0; bus.if_ready = 1; fetch_q.push_back(32'h3000);
        step();
        bus.if_ready = 0;
        step();
        chk("addr_q_left", addr_q.size(), 32'd0);
        chk("fetch_q_left", fetch_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
